// File: rtl/fetch_sequencer_if.sv
// Bus between fetch_sequencer, the combinational fetch stage and decode.
// Optional perf counters appear when FETCH_PERF_EN is defined.
interface fetch_sequencer_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
);
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instruction;
  logic [PC_W-1:0]    pc_1;
  logic               stall_i;
  logic               redirect_i;
  logic [PC_W-1:0]    redirect_pc_i;
  // if_id_valid qualifies if_id_instr/if_id_pc_1 every cycle; there is no
  // ready: decode must accept or request a hold through stall_i.
  logic               if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc_1;
  logic               halted;
`ifdef FETCH_PERF_EN
  logic [31:0]        fetch_count;
  logic [31:0]        stall_count;
`endif

  modport master (
`ifdef FETCH_PERF_EN
    output fetch_count, stall_count,
`endif
    output pc, if_id_valid, if_id_instr, if_id_pc_1, halted,
    input  instruction, pc_1, stall_i, redirect_i, redirect_pc_i
  );

  modport slave (
`ifdef FETCH_PERF_EN
    input  fetch_count, stall_count,
`endif
    input  pc, if_id_valid, if_id_instr, if_id_pc_1, halted,
    output instruction, pc_1, stall_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC register, next-PC selection and IF/ID register with a BOOT/RUN/HALT FSM.
// Define FETCH_PERF_EN to add saturating fetch/stall counters.
module fetch_sequencer #(
  parameter int              PC_W        = 16,
  parameter int              INSTR_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [5:0]      HALT_OPCODE = 6'h3F
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc1_q, pc1_d;
  logic               halted_q, halted_d;
  logic               capture;
  logic               stall_hit;
  logic               is_halt_op;

  assign is_halt_op = (bus.instruction[INSTR_W-1 -: 6] == HALT_OPCODE);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    pc1_d     = pc1_q;
    halted_d  = halted_q;
    capture   = 1'b0;
    stall_hit = 1'b0;
    if (bus.redirect_i) begin
      // Redirect wins from every state and drops whatever IF/ID held.
      pc_d     = bus.redirect_pc_i;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      state_d  = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: begin
          valid_d = 1'b0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (bus.stall_i) begin
            stall_hit = 1'b1;
          end else begin
            capture = 1'b1;
            instr_d = bus.instruction;
            pc1_d   = bus.pc_1;
            valid_d = 1'b1;
            if (is_halt_op) begin
              halted_d = 1'b1;
              state_d  = ST_HALT;
            end else begin
              pc_d = bus.pc_1;
            end
          end
        end
        ST_HALT: begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end
        default: begin
          state_d = ST_BOOT;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc1_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc1_q    <= pc1_d;
      halted_q <= halted_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (capture && (fetch_count_q != 32'hFFFF_FFFF)) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if (stall_hit && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.fetch_count = fetch_count_q;
  assign bus.stall_count = stall_count_q;
`endif

  assign bus.pc          = pc_q;
  assign bus.if_id_valid = valid_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc_1  = pc1_q;
  assign bus.halted      = halted_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a random run against
// a cycle-level reference model of the fetch rules.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  dbg_state;
  int          total = 0;
  int          bad = 0;

  fetch_sequencer_if #(.PC_W(16), .INSTR_W(32)) bus ();

  fetch_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Instruction memory: imem[n] = n unless the address is marked as a halt.
  bit halt_tab [0:65535];

  function automatic logic [31:0] imem(input logic [15:0] a);
    return halt_tab[a] ? {6'h3F, 10'h0, a} : {16'h0, a};
  endfunction

  always_comb bus.instruction = imem(bus.pc);
  assign bus.pc_1 = bus.pc + 16'd1;

  // Reference model: where fetch is, what decode holds, and whether fetch is
  // booting or parked on a halt.
  logic [15:0] m_pc = 16'h0;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'h0;
  logic [15:0] m_pc1 = 16'h0;
  logic        m_halted = 1'b0;
  bit          m_booting = 1'b1;
  logic [31:0] m_fetch = 32'h0;
  logic [31:0] m_stall = 32'h0;

  task automatic step(input bit r, input bit s, input bit rd, input logic [15:0] rpc);
    logic [31:0] ins;
    rst = r;
    bus.stall_i = s;
    bus.redirect_i = rd;
    bus.redirect_pc_i = rpc;
    ins = imem(m_pc);
    if (r) begin
      m_pc = 16'h0; m_valid = 0; m_instr = 0; m_pc1 = 0; m_halted = 0;
      m_booting = 1; m_fetch = 0; m_stall = 0;
    end else if (rd) begin
      m_pc = rpc; m_valid = 0; m_halted = 0; m_booting = 0;
    end else if (m_booting) begin
      m_booting = 0;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (s) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    end else begin
      m_instr = ins; m_pc1 = m_pc + 16'd1; m_valid = 1;
      if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 1;
      if (ins[31:26] == 6'h3F) m_halted = 1;
      else m_pc = m_pc + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 16'h0);
    total += 5;
    if (bus.pc !== 16'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0000", bus.pc); end
    if (bus.if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.if_id_valid); end
    if (bus.if_id_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", bus.if_id_instr); end
    if (bus.if_id_pc_1 !== 16'h0) begin bad++; $display("FAIL reset_pc1 got=%h exp=0", bus.if_id_pc_1); end
    if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    step(0, 0, 0, 16'h0);
    total += 2;
    if (bus.pc !== 16'h0) begin bad++; $display("FAIL boot_pc got=%h exp=0000", bus.pc); end
    if (bus.if_id_valid !== 1'b0) begin bad++; $display("FAIL boot_valid got=%b exp=0", bus.if_id_valid); end
    step(0, 0, 0, 16'h0);
    total += 4;
    if (bus.pc !== 16'h1) begin bad++; $display("FAIL run1_pc got=%h exp=0001", bus.pc); end
    if (bus.if_id_valid !== 1'b1) begin bad++; $display("FAIL run1_valid got=%b exp=1", bus.if_id_valid); end
    if (bus.if_id_instr !== 32'h0) begin bad++; $display("FAIL run1_instr got=%h exp=0", bus.if_id_instr); end
    if (bus.if_id_pc_1 !== 16'h1) begin bad++; $display("FAIL run1_pc1 got=%h exp=0001", bus.if_id_pc_1); end
    step(0, 0, 0, 16'h0);
    total += 2;
    if (bus.pc !== 16'h2) begin bad++; $display("FAIL run2_pc got=%h exp=0002", bus.pc); end
    if (bus.if_id_instr !== 32'h1) begin bad++; $display("FAIL run2_instr got=%h exp=1", bus.if_id_instr); end
  endtask

  task automatic test_stall();
    step(1, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 16'h0);
      total += 3;
      if (bus.pc !== 16'h5) begin bad++; $display("FAIL stall_pc got=%h exp=0005", bus.pc); end
      if (bus.if_id_pc_1 !== 16'h5) begin bad++; $display("FAIL stall_pc1 got=%h exp=0005", bus.if_id_pc_1); end
      if (bus.if_id_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", bus.if_id_valid); end
    end
    step(0, 0, 0, 16'h0);
    total += 2;
    if (bus.pc !== 16'h6) begin bad++; $display("FAIL unstall_pc got=%h exp=0006", bus.pc); end
    if (bus.if_id_pc_1 !== 16'h6) begin bad++; $display("FAIL unstall_pc1 got=%h exp=0006", bus.if_id_pc_1); end
`ifdef FETCH_PERF_EN
    total += 2;
    if (bus.stall_count !== m_stall) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", bus.stall_count, m_stall); end
    if (bus.fetch_count !== m_fetch) begin bad++; $display("FAIL fetch_count got=%0d exp=%0d", bus.fetch_count, m_fetch); end
`endif
  endtask

  task automatic test_redirect();
    step(1, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 16'h0);
    total++;
    if (bus.pc !== 16'h7) begin bad++; $display("FAIL redir_pre_pc got=%h exp=0007", bus.pc); end
    step(0, 1, 1, 16'h0040);
    total += 2;
    if (bus.pc !== 16'h0040) begin bad++; $display("FAIL redir_pc got=%h exp=0040", bus.pc); end
    if (bus.if_id_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", bus.if_id_valid); end
    step(0, 0, 0, 16'h0);
    total += 3;
    if (bus.if_id_pc_1 !== 16'h0041) begin bad++; $display("FAIL redir_pc1 got=%h exp=0041", bus.if_id_pc_1); end
    if (bus.if_id_valid !== 1'b1) begin bad++; $display("FAIL redir_cap_valid got=%b exp=1", bus.if_id_valid); end
    if (bus.if_id_instr !== 32'h40) begin bad++; $display("FAIL redir_instr got=%h exp=40", bus.if_id_instr); end
  endtask

  task automatic test_halt();
    halt_tab[3] = 1'b1;
    step(1, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 16'h0);
    total += 4;
    if (bus.if_id_instr !== 32'hFC00_0003) begin bad++; $display("FAIL halt_instr got=%h exp=fc000003", bus.if_id_instr); end
    if (bus.if_id_valid !== 1'b1) begin bad++; $display("FAIL halt_cap_valid got=%b exp=1", bus.if_id_valid); end
    if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", bus.halted); end
    if (bus.pc !== 16'h3) begin bad++; $display("FAIL halt_pc got=%h exp=0003", bus.pc); end
    for (int i = 0; i < 3; i++) begin
      step(0, i[0], 0, 16'h0);
      total += 3;
      if (bus.pc !== 16'h3) begin bad++; $display("FAIL halted_pc got=%h exp=0003", bus.pc); end
      if (bus.if_id_valid !== 1'b0) begin bad++; $display("FAIL halted_valid got=%b exp=0", bus.if_id_valid); end
      if (bus.halted !== 1'b1) begin bad++; $display("FAIL halted_flag got=%b exp=1", bus.halted); end
    end
    step(0, 0, 1, 16'h0010);
    total += 2;
    if (bus.halted !== 1'b0) begin bad++; $display("FAIL unhalt_flag got=%b exp=0", bus.halted); end
    if (bus.pc !== 16'h0010) begin bad++; $display("FAIL unhalt_pc got=%h exp=0010", bus.pc); end
    halt_tab[3] = 1'b0;
    step(0, 0, 0, 16'h0);
    total += 2;
    if (bus.pc !== 16'h0011) begin bad++; $display("FAIL resume_pc got=%h exp=0011", bus.pc); end
    if (bus.if_id_pc_1 !== 16'h0011) begin bad++; $display("FAIL resume_pc1 got=%h exp=0011", bus.if_id_pc_1); end
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 16'hFFFF);
    total++;
    if (bus.pc !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre_pc got=%h exp=ffff", bus.pc); end
    step(0, 0, 0, 16'h0);
    total += 3;
    if (bus.pc !== 16'h0000) begin bad++; $display("FAIL wrap_pc got=%h exp=0000", bus.pc); end
    if (bus.if_id_pc_1 !== 16'h0000) begin bad++; $display("FAIL wrap_pc1 got=%h exp=0000", bus.if_id_pc_1); end
    if (bus.if_id_instr !== 32'h0000_FFFF) begin bad++; $display("FAIL wrap_instr got=%h exp=0000ffff", bus.if_id_instr); end
  endtask

  task automatic test_reset_override();
    step(1, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 1, 16'h0020);
    step(0, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    step(1, 1, 0, 16'h0);
    total += 3;
    if (bus.pc !== 16'h0) begin bad++; $display("FAIL rst_stall_pc got=%h exp=0000", bus.pc); end
    if (bus.if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_stall_valid got=%b exp=0", bus.if_id_valid); end
    if (bus.halted !== 1'b0) begin bad++; $display("FAIL rst_stall_halted got=%b exp=0", bus.halted); end
`ifdef FETCH_PERF_EN
    total += 2;
    if (bus.fetch_count !== 32'h0) begin bad++; $display("FAIL rst_fetch_count got=%0d exp=0", bus.fetch_count); end
    if (bus.stall_count !== 32'h0) begin bad++; $display("FAIL rst_stall_count got=%0d exp=0", bus.stall_count); end
`endif
    halt_tab[16'h21] = 1'b1;
    step(0, 0, 0, 16'h0);
    step(0, 0, 1, 16'h0020);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    total++;
    if (bus.halted !== 1'b1) begin bad++; $display("FAIL pre_rst_halted got=%b exp=1", bus.halted); end
    step(1, 0, 1, 16'h0030);
    total += 3;
    if (bus.pc !== 16'h0) begin bad++; $display("FAIL rst_halt_pc got=%h exp=0000", bus.pc); end
    if (bus.if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_halt_valid got=%b exp=0", bus.if_id_valid); end
    if (bus.halted !== 1'b0) begin bad++; $display("FAIL rst_halt_halted got=%b exp=0", bus.halted); end
`ifdef FETCH_PERF_EN
    total += 2;
    if (bus.fetch_count !== 32'h0) begin bad++; $display("FAIL rst_halt_fetch got=%0d exp=0", bus.fetch_count); end
    if (bus.stall_count !== 32'h0) begin bad++; $display("FAIL rst_halt_stall got=%0d exp=0", bus.stall_count); end
`endif
    halt_tab[16'h21] = 1'b0;
  endtask

  task automatic test_random();
    int errs;
    step(1, 0, 0, 16'h0);
    for (int i = 0; i < 6; i++) halt_tab[16'($urandom_range(1, 63))] = 1'b1;
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, 16'($urandom_range(0, 63)));
      errs = 0;
      if (bus.pc !== m_pc) errs++;
      if (bus.if_id_valid !== m_valid) errs++;
      if (bus.if_id_instr !== m_instr) errs++;
      if (bus.if_id_pc_1 !== m_pc1) errs++;
      if (bus.halted !== m_halted) errs++;
`ifdef FETCH_PERF_EN
      if (bus.fetch_count !== m_fetch) errs++;
      if (bus.stall_count !== m_stall) errs++;
`endif
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL random cyc=%0d got pc=%h v=%b i=%h p1=%h h=%b exp pc=%h v=%b i=%h p1=%h h=%b",
                 n, bus.pc, bus.if_id_valid, bus.if_id_instr, bus.if_id_pc_1, bus.halted,
                 m_pc, m_valid, m_instr, m_pc1, m_halted);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 16'h0;
    for (int i = 0; i < 65536; i++) halt_tab[i] = 1'b0;
    #1;
    test_reset();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_override();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
